// File: rtl/des_expand_pipe.sv
// DES E-expansion (32 -> 48 bits per lane) with optional subkey XOR,
// followed by an elastic valid/ready register pipeline of STAGES deep.
// Lane l sits at bus bits [32l+31:32l] (data), [48l+47:48l] (key/result);
// within a lane DES bit 0 is the lane MSB.

// Per-lane combinational expansion and key mix.
module des_expand_lane (
    input  logic [31:0] d,
    input  logic [47:0] key,
    input  logic        mode,
    output logic [47:0] r
);
    logic [47:0] e;

    // DES bit i maps to vector bit 31-i (data) / 47-i (expanded).
    for (genvar g = 0; g < 8; g++) begin : g_grp
        assign e[47-6*g]        = d[31-((4*g+31)%32)];
        assign e[46-6*g -: 4]   = d[31-4*g -: 4];
        assign e[42-6*g]        = d[31-((4*g+4)%32)];
    end

    assign r = mode ? (e ^ key) : e;
endmodule

module des_expand_pipe #(
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [LANES*32-1:0] in_data,
    input  logic [LANES*48-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*48-1:0] out_data
);
    localparam int W = LANES*48;

    logic [W-1:0]              res;
    logic [STAGES-1:0]         vld;
    logic [STAGES-1:0]         adv;
    logic [STAGES-1:0]         prv_vld;
    logic [STAGES-1:0][W-1:0]  dat;
    logic [STAGES-1:0][W-1:0]  prv_dat;
    logic                      fire;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        des_expand_lane u_lane (
            .d    (in_data[32*l +: 32]),
            .key  (in_key[48*l +: 48]),
            .mode (in_mode),
            .r    (res[48*l +: 48])
        );
    end

    // A stage can take new contents when the output drains or any stage
    // from here to the tail is empty (bubbles collapse toward the output).
    for (genvar s = 0; s < STAGES; s++) begin : g_adv
        assign adv[s] = out_ready || !(&vld[STAGES-1:s]);
    end

    assign in_ready  = !flush && adv[0];
    assign fire      = in_valid && in_ready;
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign prv_vld[s] = fire;
            assign prv_dat[s] = res;
        end else begin : g_body
            assign prv_vld[s] = vld[s-1];
            assign prv_dat[s] = dat[s-1];
        end

        // Stage register: flush drops valids only; data loads with a valid beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[s] <= 1'b0;
                dat[s] <= '0;
            end else if (flush) begin
                vld[s] <= 1'b0;
            end else if (adv[s]) begin
                vld[s] <= prv_vld[s];
                if (prv_vld[s]) dat[s] <= prv_dat[s];
            end
        end
    end
endmodule

// File: tb/tb_des_expand_pipe.sv
// Bench for des_expand_pipe: directed DES vectors, randomized traffic against
// a table-driven expansion model plus an in-order expected-beat queue.
module tb_des_expand_pipe;
    localparam int LANES  = 4;
    localparam int STAGES = 3;
    localparam int DW     = LANES*32;
    localparam int KW     = LANES*48;

    logic          clk = 0, rst_n = 1, flush = 0, in_valid = 0, in_mode = 0, out_ready = 0;
    logic          in_ready, out_valid;
    logic [DW-1:0] in_data = '0;
    logic [KW-1:0] in_key = '0;
    logic [KW-1:0] out_data;

    int ncmp = 0, nfail = 0, nacc = 0, npop = 0;
    logic [KW-1:0] expq[$];
    logic last_fire = 0;

    // Standard DES E table, 1-based source positions.
    int etab [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                       8, 9,10,11,12,13,12,13,14,15,16,17,
                      16,17,18,19,20,21,20,21,22,23,24,25,
                      24,25,26,27,28,29,28,29,30,31,32, 1};

    des_expand_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [KW-1:0] model(logic [DW-1:0] d, logic [KW-1:0] k, logic m);
        logic [KW-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++)
            for (int i = 0; i < 48; i++)
                r[48*l + 47 - i] = d[32*l + 31 - (etab[i] - 1)];
        if (m) r = r ^ k;
        return r;
    endfunction

    task automatic chk(string tag, logic [KW-1:0] obs, logic [KW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check handshake/output against the model, advance, update model.
    task automatic cycle();
        logic fire, pop;
        #2;
        chk("in_ready", KW'(in_ready), KW'(!flush && (expq.size() < STAGES || out_ready)));
        if (out_valid) begin
            if (expq.size() == 0) chk("out_valid_empty", KW'(out_valid), '0);
            else                  chk("out_data", out_data, expq[0]);
        end
        fire = in_valid && in_ready;
        pop  = out_valid && out_ready;
        @(posedge clk); #1;
        if (pop && expq.size() > 0) begin void'(expq.pop_front()); npop++; end
        if (flush) expq.delete();
        if (fire) begin expq.push_back(model(in_data, in_key, in_mode)); nacc++; end
        last_fire = fire;
    endtask

    task automatic rand_beat();
        for (int w = 0; w < LANES; w++)     in_data[32*w +: 32] = $urandom;
        for (int w = 0; w < LANES*3/2; w++) in_key[32*w +: 32]  = $urandom;
        in_mode = 1'($urandom);
    endtask

    // Single beat through an idle pipe with out_ready high: check latency.
    task automatic latency(string tag, logic [DW-1:0] d, logic [KW-1:0] k, logic m,
                           logic [KW-1:0] exp);
        in_data = d; in_key = k; in_mode = m; in_valid = 1; out_ready = 1;
        cycle();
        in_valid = 0; in_mode = ~m; in_key = ~k;
        chk({tag, "_v0"}, KW'(out_valid), '0);
        cycle();
        chk({tag, "_v1"}, KW'(out_valid), '0);
        cycle();
        chk({tag, "_v2"}, KW'(out_valid), KW'(1));
        chk({tag, "_data"}, out_data, exp);
        cycle();
        chk({tag, "_alone"}, KW'(out_valid), '0);
    endtask

    task automatic drain();
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 20 && expq.size() > 0; i++) cycle();
        chk("drain_empty", KW'(expq.size()), '0);
    endtask

    initial begin
        logic [KW-1:0] hold;
        int n;

        // Reset
        #1 rst_n = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", KW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        rst_n = 1;
        #1 chk("rst_in_ready", KW'(in_ready), KW'(1));

        // Directed vectors, replicated across all lanes
        latency("vec_mode0", {LANES{32'hF0AAF0AA}}, {LANES{48'h123456789ABC}}, 1'b0,
                {LANES{48'h7A15557A1555}});
        latency("vec_mode1", {LANES{32'hF0AAF0AA}}, {LANES{48'h1B02EFFC7072}}, 1'b1,
                {LANES{48'h6117BA866527}});
        latency("vec_wrap_lsb", {LANES{32'h00000001}}, {LANES{48'hFFFFFFFFFFFF}}, 1'b0,
                {LANES{48'h800000000002}});
        latency("vec_wrap_msb", {LANES{32'h80000000}}, '0, 1'b0,
                {LANES{48'h400000000001}});

        // Random traffic with random backpressure; beat held until accepted
        nacc = 0; npop = 0;
        last_fire = 1;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || last_fire) begin
                in_valid = ($urandom % 4) != 0;
                rand_beat();
            end
            out_ready = 1'($urandom);
            cycle();
        end
        drain();
        chk("rand_count", KW'(npop), KW'(nacc));

        // Capacity with output stalled
        out_ready = 0; in_valid = 1; rand_beat(); n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_fire) begin n++; rand_beat(); end
            else break;
        end
        chk("capacity", KW'(n), KW'(STAGES));
        chk("full_in_ready", KW'(in_ready), '0);

        // Stall: output stable for 5 cycles
        hold = out_data;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid", KW'(out_valid), KW'(1));
            chk("stall_hold", out_data, hold);
        end

        // Release: one beat per cycle, in_ready stays high
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_fire) rand_beat();
            chk("release_rdy", KW'(in_ready), KW'(1));
            chk("release_valid", KW'(out_valid), KW'(1));
        end
        drain();

        // Flush with two beats in flight
        out_ready = 0; in_valid = 1; rand_beat();
        cycle(); rand_beat();
        cycle();
        in_valid = 0; flush = 1;
        cycle();
        flush = 0;
        chk("flush_empty", KW'(out_valid), '0);
        cycle();
        chk("flush_empty2", KW'(out_valid), '0);
        rand_beat();
        latency("post_flush", in_data, in_key, in_mode, model(in_data, in_key, in_mode));

        // Asynchronous reset mid-stream
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin rand_beat(); cycle(); end
        in_valid = 0;
        chk("pre_rst_valid", KW'(out_valid), KW'(1));
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", KW'(out_valid), '0);
        chk("async_rst_data", out_data, '0);
        expq.delete();
        @(posedge clk); #1;
        rst_n = 1;
        out_ready = 1;
        cycle();
        chk("post_rst_valid", KW'(out_valid), '0);
        latency("post_rst", {LANES{32'hF0AAF0AA}}, {LANES{48'h1B02EFFC7072}}, 1'b1,
                {LANES{48'h6117BA866527}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
